// File: rtl/reg32_readout.sv
// reg32_readout: captures a register word on start and streams it out serially over valid/ready.
// Optional even-parity trailer item is enabled by defining READOUT_PARITY_EN.
module reg32_readout #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_last,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef READOUT_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   shadow_r;
    logic [WIDTH-1:0]   shadow_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
`ifdef READOUT_PARITY_EN
    logic               parity_r;
    logic               parity_s;
`endif

    logic               sdo_r;
    logic               sdo_valid_r;
    logic               sdo_last_r;
    logic               busy_r;
    logic               done_r;
    logic               sdo_s;
    logic               sdo_valid_s;
    logic               sdo_last_s;
    logic               busy_s;
    logic               done_s;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    // Next-state logic plus decode of the next-cycle outputs, so outputs come straight from flops.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        cnt_s    = cnt_r;
`ifdef READOUT_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    shadow_s = d;
                    cnt_s    = CNT_W'(WIDTH - 1);
`ifdef READOUT_PARITY_EN
                    parity_s = even_parity(d);
`endif
                    state_s  = SHIFT;
                end else begin
                    state_s  = IDLE;
                end
            end
            SHIFT: begin
                if (ready) begin
                    shadow_s = shift_one(shadow_r);
                    cnt_s    = cnt_r - CNT_W'(1);
                    if (cnt_r == '0) begin
`ifdef READOUT_PARITY_EN
                        state_s = PAR;
`else
                        state_s = DONE;
`endif
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
`ifdef READOUT_PARITY_EN
            PAR: begin
                if (ready) begin
                    state_s = DONE;
                end else begin
                    state_s = PAR;
                end
            end
`endif
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
`ifdef READOUT_PARITY_EN
        sdo_valid_s = (state_s == SHIFT) || (state_s == PAR);
        sdo_last_s  = (state_s == PAR);
        if (state_s == PAR) begin
            sdo_s = parity_s;
        end else begin
            sdo_s = out_bit(shadow_s);
        end
`else
        sdo_valid_s = (state_s == SHIFT);
        sdo_last_s  = (state_s == SHIFT) && (cnt_s == '0);
        sdo_s       = out_bit(shadow_s);
`endif
    end

    // State, shadow and counter registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            shadow_r <= '0;
            cnt_r    <= '0;
`ifdef READOUT_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            shadow_r <= shadow_s;
            cnt_r    <= cnt_s;
`ifdef READOUT_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

    // Output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdo_r       <= 1'b0;
            sdo_valid_r <= 1'b0;
            sdo_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            sdo_r       <= sdo_s;
            sdo_valid_r <= sdo_valid_s;
            sdo_last_r  <= sdo_last_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign sdo       = sdo_r;
    assign sdo_valid = sdo_valid_r;
    assign sdo_last  = sdo_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/reg32_readout.md
# reg32_readout

Parallel-to-serial readout engine for 32-bit register values. On a `start` request it captures a word from a `reg32`-style register output (`d`) into a private shadow register. It then streams the word out one bit per accepted transfer over a valid/ready serial interface and signals completion with a one-cycle `done` pulse. It is the read side of the enable-loaded register path, used for debug and readback of datapath registers.

## Interface
Parameters:
- `WIDTH`, 32, number of data bits captured and shifted; legal values are ≥ 2.
- `LSB_FIRST`, 0, bit order: 0 sends bit WIDTH-1 first, 1 sends bit 0 first.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d`  in  WIDTH  word to read out; sampled only on an accepted `start`.
- `start`  in  1  readout request; honoured only in IDLE.
- `ready`  in  1  downstream accepts the current serial bit.
- `sdo`  out  WIDTH-independent 1  current serial bit.
- `sdo_valid`  out  1  `sdo` is valid.
- `sdo_last`  out  1  current item is the final one of the frame.
- `busy`  out  1  engine is not in IDLE.
- `done`  out  1  one-cycle pulse after the final item is accepted.

## Operation
- States: IDLE, SHIFT, PAR (only with the macro), DONE.
- **IDLE**
  - Outputs `busy`, `sdo_valid`, `sdo_last` and `done` are 0.
  - When `start`=1, the engine captures `d` into the shadow, loads the remaining-bit counter with WIDTH-1 (counter width is $clog2(WIDTH)), and moves to SHIFT.
- **SHIFT**
  - `sdo_valid`=1.
  - `sdo` is shadow[WIDTH-1], or shadow[0] when LSB_FIRST=1.
  - On `sdo_valid && ready`:
    - the shadow shifts one position toward the output end;
    - the counter decrements;
    - when the counter is 0, the accepted bit was the last data bit and the engine moves to PAR (macro) or DONE.
- `ready`=0: `sdo`, the shadow and the counter hold. There is no timeout.
- `sdo_last`=1 only while the final item is presented: the counter is 0 in SHIFT without the macro, or the state is PAR with the macro.
- **DONE**
  - `done`=1 for exactly one cycle, `busy`=1, `sdo_valid`=0.
  - Next state is always IDLE.
- `start` in SHIFT, PAR or DONE is ignored and not queued.
- Changes on `d` after capture do not affect the stream.
- `busy` = (state ≠ IDLE).

## Timing
- Reset value of all outputs is 0. The shadow, counter and state reset to 0/IDLE.
- `rst_n` low mid-frame aborts immediately (asynchronous). There is no `done` pulse, and the frame is lost.
- With `start` sampled in cycle N and `ready` held at 1:
  - first bit is valid in N+1;
  - last data bit is in N+WIDTH;
  - `done` is high in N+WIDTH+1;
  - IDLE is reached in N+WIDTH+2, which is the earliest cycle a new `start` is accepted.
- Each `ready`=0 cycle while `sdo_valid`=1 adds exactly one cycle to the frame.
- All outputs are registered or decoded from state only. There is no combinational path from `ready` or `start` to any output.

## Configuration
- Macro: `READOUT_PARITY_EN`.
- Defined:
  - an even-parity bit (XOR of all WIDTH captured bits) is computed at capture;
  - that bit is sent in state PAR after the last data bit, with the same valid/ready rules and `sdo_last`=1;
  - the frame is WIDTH+1 items, and `done` is at N+WIDTH+2 with `ready`=1.
- Undefined:
  - there is no PAR state and no parity logic;
  - the frame is WIDTH items.

## Test plan
- **Reset.** Hold `rst_n`=0 with `start`=1 and `ready`=1 → all outputs stay 0. Deassert `rst_n` → the engine stays idle until `start` is sampled with `rst_n` high.
- **Basic MSB-first frame.** WIDTH=32, `d`=0xA5A5_0F0F, `ready`=1, `start` in N → `sdo` sequence is 1,0,1,0,0,1,0,1,… ending 1,1,1,1. `sdo_last` is high only in N+32, `done` only in N+33, and `busy` is high N+1..N+33.
- **Backpressure and ignored inputs.**
  - `d`=0xDEAD_BEEF; drive `ready`=0 for 3 cycles after bit 5 → the stream is unchanged and `done` is at N+36.
  - Pulse `start` and change `d` to 0 mid-frame → no effect on the stream.
- **Reset mid-frame.** Assert `rst_n`=0 during bit 10 → outputs go to 0 asynchronously with no `done`. A new `start` with `d`=0x0000_0001 then produces 31 zeros followed by a 1.
- **LSB_FIRST=1.** `d`=0x0000_0003 → first two bits are 1,1, followed by 30 zeros.
- **Parity, `READOUT_PARITY_EN` defined.**
  - `d`=0x0000_0007 → 33 items, the last item is 1 with `sdo_last`=1, and `done` is at N+34.
  - `d`=0x8000_0001 → the parity item is 0.
